// File: rtl/servo_sequencer_if.sv
// Button/enable requests in, per-channel servo levels and status out; purely combinational bundle.
interface servo_sequencer_if;
    logic [3:0] btn;
    logic       enable;
    logic       s1, s2, s3, s4;
    logic       f1, f2, f3, f4;
    logic       busy;
    logic       done;
    logic [3:0] pending;

    modport master (
        output btn, enable,
        input  s1, s2, s3, s4, f1, f2, f3, f4, busy, done, pending
    );

    modport slave (
        input  btn, enable,
        output s1, s2, s3, s4, f1, f2, f3, f4, busy, done, pending
    );
endinterface

// File: rtl/servo_sequencer.sv
// Debounced buttons queue requests; one channel at a time runs open/push/retract/close, DEB+2 cycles press-to-pending.
// No backpressure: requests latch in pending while busy or disabled, and a started sequence always completes.
module servo_sequencer #(
    parameter int DEB_CYCLES    = 500000,
    parameter int SETTLE_CYCLES = 10000000,
    parameter int HOLD_CYCLES   = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    servo_sequencer_if.slave   io
);
    localparam int MAXD = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_OPEN, S_PUSH, S_RETRACT, S_CLOSE} state_t;

    logic [3:0]    r_meta, r_sync, r_deb, r_pend;
    logic [DW-1:0] r_cnt [4];
    logic [3:0]    w_rise, w_clr, w_sel_oh, w_k_oh;
    logic [1:0]    w_sel;
    logic          w_start, w_last;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_k;
    logic [3:0]    r_s, r_f;
    logic          r_busy, r_done;

    // The counter tracks how long the synced level has disagreed with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_deb  <= '0;
            for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
        end else begin
            r_meta <= io.btn;
            r_sync <= r_meta;
            for (int n = 0; n < 4; n++) begin
                if (r_sync[n] == r_deb[n]) begin
                    r_cnt[n] <= '0;
                end else if (r_cnt[n] == DEB_LAST) begin
                    r_deb[n] <= r_sync[n];
                    r_cnt[n] <= '0;
                end else begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rise = '0;
        w_sel  = '0;
        for (int n = 0; n < 4; n++)
            w_rise[n] = r_sync[n] & ~r_deb[n] & (r_cnt[n] == DEB_LAST);
        for (int n = 3; n >= 0; n--)
            if (r_pend[n]) w_sel = 2'(n);
        w_sel_oh = 4'b0001 << w_sel;
        w_k_oh   = 4'b0001 << r_k;
        w_start  = (r_state == S_IDLE) && io.enable && (r_pend != 4'b0000);
        w_clr    = w_start ? w_sel_oh : 4'b0000;
        w_last   = (r_state == S_PUSH) ? (r_timer == HOLD_LAST) : (r_timer == SETTLE_LAST);
    end

    // A fresh edge on the bit being cleared wins, so the request is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (r_pend & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_k     <= '0;
            r_s     <= '0;
            r_f     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_timer <= w_last ? '0 : r_timer + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_start) begin
                        r_k     <= w_sel;
                        r_f     <= w_sel_oh;
                        r_busy  <= 1'b1;
                        r_state <= S_OPEN;
                    end
                end
                S_OPEN: if (w_last) begin
                    r_s     <= w_k_oh;
                    r_state <= S_PUSH;
                end
                S_PUSH: if (w_last) begin
                    r_s     <= '0;
                    r_state <= S_RETRACT;
                end
                S_RETRACT: if (w_last) begin
                    r_f     <= '0;
                    r_state <= S_CLOSE;
                end
                S_CLOSE: if (w_last) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io.s1      = r_s[0];
    assign io.s2      = r_s[1];
    assign io.s3      = r_s[2];
    assign io.s4      = r_s[3];
    assign io.f1      = r_f[0];
    assign io.f2      = r_f[1];
    assign io.f3      = r_f[2];
    assign io.f4      = r_f[3];
    assign io.busy    = r_busy;
    assign io.done    = r_done;
    assign io.pending = r_pend;
endmodule

// File: tb/tb_servo_sequencer.sv
// Directed scenarios plus random presses, every cycle compared against a sequence-level reference model.
module tb_servo_sequencer;
    localparam int DEB   = 4;
    localparam int SET   = 8;
    localparam int HLD   = 16;
    localparam int TOTAL = 3 * SET + HLD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    servo_sequencer_if ifc();

    servo_sequencer #(
        .DEB_CYCLES(DEB), .SETTLE_CYCLES(SET), .HOLD_CYCLES(HLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (ifc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: raw button history, accepted levels, request set, and position within the current sequence.
    logic [3:0] hist [0:DEB];
    logic [3:0] m_deb, m_pend;
    bit         m_act, m_done;
    int         m_k, m_el;

    task automatic model_reset();
        for (int i = 0; i <= DEB; i++) hist[i] = 4'b0000;
        m_deb = '0; m_pend = '0; m_act = 0; m_done = 0; m_k = 0; m_el = 0;
    endtask

    task automatic model_edge();
        logic [3:0] set, clr;
        bit all_other;
        set = '0; clr = '0;
        for (int n = 0; n < 4; n++) begin
            all_other = 1;
            for (int i = 1; i <= DEB; i++)
                if (hist[i][n] == m_deb[n]) all_other = 0;
            if (all_other) begin
                m_deb[n] = ~m_deb[n];
                if (m_deb[n]) set[n] = 1'b1;
            end
        end
        for (int i = DEB; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = ifc.btn;
        m_done = 0;
        if (m_act) begin
            m_el++;
            if (m_el == TOTAL) begin
                m_act  = 0;
                m_done = 1;
            end
        end else if (ifc.enable && m_pend != 4'b0000) begin
            m_k = 0;
            while (!m_pend[m_k]) m_k++;
            clr[m_k] = 1'b1;
            m_act = 1;
            m_el  = 0;
        end
        m_pend = (m_pend & ~clr) | set;
    endtask

    function automatic logic [3:0] exp_f();
        return (m_act && m_el < 2 * SET + HLD) ? (4'b0001 << m_k) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_s();
        return (m_act && m_el >= SET && m_el < SET + HLD) ? (4'b0001 << m_k) : 4'b0000;
    endfunction

    task automatic compare_all();
        chk("pending", 32'(ifc.pending), 32'(m_pend));
        chk("busy",    32'(ifc.busy),    32'(m_act));
        chk("done",    32'(ifc.done),    32'(m_done));
        chk("s_vec",   32'({ifc.s4, ifc.s3, ifc.s2, ifc.s1}), 32'(exp_s()));
        chk("f_vec",   32'({ifc.f4, ifc.f3, ifc.f2, ifc.f1}), 32'(exp_f()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int t_p, t_f, t_s, t_d, nf, ns, nr, nf3, t_p3, t_f3, t_f2, t_f4, t_d1, nb, np, k, hold;
        logic prev_p, prev_f;

        rst = 1'b1;
        ifc.btn = 4'b0000;
        ifc.enable = 1'b1;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // Single press on channel 1
        t_p = -1; t_f = -1; t_s = -1; t_d = -1; nf = 0; ns = 0;
        ifc.btn = 4'b0001;
        for (int i = 1; i <= 80; i++) begin
            if (i == 11) ifc.btn = 4'b0000;
            step();
            if (ifc.pending[0] && t_p < 0) t_p = i;
            if (ifc.f1) begin nf++; if (t_f < 0) t_f = i; end
            if (ifc.s1) begin ns++; if (t_s < 0) t_s = i; end
            if (ifc.done && t_d < 0) t_d = i;
        end
        chk("press_to_pending_ok", 32'(t_p > 0 && t_p <= DEB + 3), 32'd1);
        chk("pending_to_f1", 32'(t_f - t_p), 32'd1);
        chk("f1_high_len", 32'(nf), 32'(2 * SET + HLD));
        chk("s1_high_len", 32'(ns), 32'(HLD));
        chk("s1_after_f1", 32'(t_s - t_f), 32'(SET));
        chk("done_after_f1", 32'(t_d - t_f), 32'(TOTAL));

        // Bounce on channel 3
        nr = 0; nf3 = 0; t_p3 = -1; t_f3 = -1; prev_p = 0; prev_f = 0;
        for (int i = 0; i < 120; i++) begin
            if (i < 20)      ifc.btn = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
            else if (i < 35) ifc.btn = 4'b0100;
            else             ifc.btn = 4'b0000;
            step();
            if (ifc.pending[2] && !prev_p) begin nr++; if (t_p3 < 0) t_p3 = i; end
            if (ifc.f3 && !prev_f) begin nf3++; if (t_f3 < 0) t_f3 = i; end
            prev_p = ifc.pending[2];
            prev_f = ifc.f3;
        end
        chk("bounce_one_request", 32'(nr), 32'd1);
        chk("bounce_one_sequence", 32'(nf3), 32'd1);
        chk("bounce_after_stable", 32'(t_p3 >= 20 + DEB), 32'd1);
        chk("bounce_pending_to_f3", 32'(t_f3 - t_p3), 32'd1);

        // Simultaneous presses on channels 2 and 4
        t_f2 = -1; t_f4 = -1; t_d1 = -1;
        ifc.btn = 4'b1010;
        for (int i = 0; i < 130; i++) begin
            if (i == 10) ifc.btn = 4'b0000;
            step();
            if (ifc.f2 && t_f2 < 0) t_f2 = i;
            if (ifc.f4 && t_f4 < 0) t_f4 = i;
            if (ifc.done && t_d1 < 0) t_d1 = i;
        end
        chk("prio_ch2_first", 32'(t_f2 >= 0 && t_f2 < t_f4), 32'd1);
        chk("prio_idle_gap", 32'(t_f4 - t_d1), 32'd1);

        // Enable gating
        ifc.enable = 1'b0;
        nb = 0;
        ifc.btn = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) ifc.btn = 4'b0000;
            step();
            if (ifc.busy) nb++;
        end
        chk("gate_pending", 32'(ifc.pending), 32'd1);
        chk("gate_no_busy", 32'(nb), 32'd0);
        ifc.enable = 1'b1;
        step();
        chk("gate_start_f1", 32'(ifc.f1), 32'd1);
        repeat (TOTAL + 5) step();

        // Reset five cycles into PUSH
        ifc.btn = 4'b0001;
        repeat (10) step();
        ifc.btn = 4'b0000;
        k = 0;
        while (!ifc.s1 && k < 40) begin step(); k++; end
        chk("push_reached", 32'(ifc.s1), 32'd1);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_s", 32'({ifc.s4, ifc.s3, ifc.s2, ifc.s1}), 32'd0);
        chk("rst_async_f", 32'({ifc.f4, ifc.f3, ifc.f2, ifc.f1}), 32'd0);
        chk("rst_async_pending", 32'(ifc.pending), 32'd0);
        chk("rst_async_busy", 32'(ifc.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ifc.busy) nb++;
        end
        chk("post_reset_idle", 32'(nb), 32'd0);

        // Re-request during channel 2 PUSH
        ifc.btn = 4'b0010;
        repeat (10) step();
        ifc.btn = 4'b0000;
        k = 0;
        while (!ifc.s2 && k < 40) begin step(); k++; end
        chk("ch2_push_reached", 32'(ifc.s2), 32'd1);
        np = 0; nr = 0; prev_f = ifc.f2;
        ifc.btn = 4'b0010;
        for (int i = 0; i < 130; i++) begin
            if (i == 10) ifc.btn = 4'b0000;
            step();
            if (ifc.pending[1] && i < 20) np++;
            if (ifc.f2 && !prev_f) nr++;
            prev_f = ifc.f2;
        end
        chk("rereq_pending", 32'(np > 0), 32'd1);
        chk("rereq_second_seq", 32'(nr), 32'd1);

        // Random presses, durations and enable
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                ifc.btn    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                ifc.enable = ($urandom_range(0, 7) != 0);
                hold       = $urandom_range(1, 12);
            end
            hold--;
            step();
        end
        ifc.btn = 4'b0000;
        ifc.enable = 1'b1;
        repeat (250) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/servo_sequencer.md
# servo_sequencer

Command sequencer that sits directly upstream of the servo PWM stage and generates its level inputs s1..s4 (pusher servos) and f1..f4 (flap servos). Converts four raw push-button requests into a serialized open-flap / push / retract / close-flap sequence per channel. Only one mechanism moves at a time, which bounds servo supply current. All outputs are registered levels held for the whole of each phase, so the PWM stage sees stable positions across many 20 ms frames.

## Interface
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- SETTLE_CYCLES, 10000000: duration of each flap-open, retract and flap-close phase (200 ms).
- HOLD_CYCLES, 25000000: duration of the push phase (500 ms).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- btn  in  4  raw asynchronous buttons, active-high; bit n maps to channel n+1.
- enable  in  1  when low, no new sequence starts; a sequence in progress always completes.
- s1..s4  out  1 each  pusher command to the PWM stage; 1 = extended.
- f1..f4  out  1 each  flap command to the PWM stage; 1 = open.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse on the CLOSE_FLAP→IDLE transition.
- pending  out  4  latched, not-yet-started requests.

## Operation
- Per bit: 2-FF synchronizer, then debouncer.
  - A counter resets on every change of the synchronized level.
  - The debounced level updates when the synchronized level has been stable for DEB_CYCLES cycles.
- A debounced 0→1 transition on bit n sets pending[n]. Falling edges are ignored.
- FSM states: IDLE, OPEN_FLAP, PUSH, RETRACT, CLOSE_FLAP.
  - IDLE: if enable=1 and pending≠0, select the lowest set index k, clear pending[k], store k, and go to OPEN_FLAP.
  - OPEN_FLAP: f(k)=1, s(k)=0. Lasts SETTLE_CYCLES, then PUSH.
  - PUSH: f(k)=1, s(k)=1. Lasts HOLD_CYCLES, then RETRACT.
  - RETRACT: f(k)=1, s(k)=0. Lasts SETTLE_CYCLES, then CLOSE_FLAP.
  - CLOSE_FLAP: f(k)=0, s(k)=0. Lasts SETTLE_CYCLES, then IDLE, with done=1 for one cycle.
- Every s/f output of a non-selected channel is 0 in all states.
- Phase timer width is ceil(log2(max(HOLD_CYCLES, SETTLE_CYCLES))) bits.
  - The timer loads 0 on each state entry.
  - The state exits when timer = duration−1, so each state lasts exactly its parameter in cycles.
- A new edge on the channel being serviced sets its pending bit again. That request is served after the current sequence completes, subject to priority.
- A pending bit setting in the same cycle the FSM clears a different bit: both actions take effect.
- A pending bit setting in the same cycle the FSM clears the same bit: the set wins and the bit stays 1.
- enable falling mid-sequence: the sequence finishes normally and pending bits are retained.

## Timing
- Reset (async assert): s1..s4=0, f1..f4=0, busy=0, done=0, pending=0, FSM in IDLE. Timers, debouncers and synchronizers are cleared to 0, with debounced level 0.
- Reset mid-sequence: all outputs drop to 0 immediately, without waiting for a clock edge. After release, the FSM waits for new requests.
- Release of reset is synchronous to clk and takes effect on the first rising edge with rst=0.
- btn rising edge to pending set: at most DEB_CYCLES+3 cycles.
- pending set to f(k)=1: 1 cycle (IDLE samples pending, registers the outputs).
- Full sequence length: 3·SETTLE_CYCLES + HOLD_CYCLES cycles from the first OPEN_FLAP cycle to the done pulse. IDLE lasts at least 1 cycle between sequences.
- busy rises with OPEN_FLAP entry and falls in the same cycle done pulses.

## Test plan
Bench parameters: DEB_CYCLES=4, SETTLE_CYCLES=8, HOLD_CYCLES=16.
- Single press: btn=0001 held for 10 cycles.
  - pending[0] sets within 7 cycles.
  - f1 is high for exactly 32 cycles; s1 is high for 16 cycles, starting 8 cycles after f1 rises.
  - done pulses 40 cycles after f1 rises; all other outputs stay 0.
- Bounce: btn[2] toggles every 2 cycles for 20 cycles, then holds 1.
  - Exactly one request is accepted, and it is accepted only after the stable period.
  - The pending[2] set reaches f3 one cycle later.
- Priority: btn=1010 pressed simultaneously.
  - Channel 2 is served first and channel 4 second.
  - There is exactly one IDLE cycle between the done pulse and f4 rising.
- Enable gating: enable=0 and btn[0] pressed.
  - pending=0001 and busy stays 0.
  - Raising enable starts OPEN_FLAP on the next cycle.
- Reset mid-PUSH: assert rst 5 cycles into PUSH.
  - s and f go to 0 asynchronously and pending clears.
  - After release, with no press, busy stays 0 for 50 cycles.
- Re-request: press btn[1] during channel 2's PUSH.
  - pending[1] reasserts.
  - A second full channel 2 sequence follows after done.
